// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshakes, configurable EXEC latency, optional hit timeout and retired-instruction count.
module multicycle_control_unit #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             iREN,
    output logic             irWEN,
    output logic             pcWEN,
    output logic             dREN,
    output logic             dWEN,
    output logic             regWEN,
    output logic [1:0]       regsrc,
    output logic [1:0]       regdst,
    output logic             extsel,
    output logic [1:0]       alusrc,
    output logic [3:0]       aluop,
    output logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] RS_ALU = 2'd0;
    localparam logic [1:0] RS_MEM = 2'd1;
    localparam logic [1:0] RS_PC  = 2'd2;
    localparam logic [1:0] RS_LUI = 2'd3;
    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;
    localparam logic       EXT_ZERO = 1'b0;
    localparam logic       EXT_SIGN = 1'b1;
    localparam logic [1:0] AS_REG   = 2'd0;
    localparam logic [1:0] AS_IMM   = 2'd1;
    localparam logic [1:0] AS_SHAMT = 2'd2;

    localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]    state, nstate;
    logic [TW-1:0] wcnt;
    logic [3:0]    ecnt;
    logic          d_legal, d_extsel;
    logic [1:0]    d_regsrc, d_regdst, d_alusrc;
    logic [3:0]    d_aluop;
    logic          is_lw, is_sw, is_beq, is_bne, is_jal, is_jmp;
    logic          exec_last, wait_hit, timeout, taken, active, retire;

    always_comb begin
        d_legal  = 1'b1;
        d_regsrc = RS_ALU;
        d_regdst = RD_RT;
        d_extsel = EXT_ZERO;
        d_alusrc = AS_REG;
        d_aluop  = ALU_SLL;
        case (opcode)
            OP_RTYPE: begin
                d_regdst = RD_RD;
                case (funct)
                    F_SLL:         begin d_aluop = ALU_SLL; d_alusrc = AS_SHAMT; end
                    F_SRL:         begin d_aluop = ALU_SRL; d_alusrc = AS_SHAMT; end
                    F_ADD, F_ADDU: d_aluop = ALU_ADD;
                    F_SUB, F_SUBU: d_aluop = ALU_SUB;
                    F_AND:         d_aluop = ALU_AND;
                    F_OR:          d_aluop = ALU_OR;
                    F_XOR:         d_aluop = ALU_XOR;
                    F_NOR:         d_aluop = ALU_NOR;
                    F_SLT:         d_aluop = ALU_SLT;
                    F_SLTU:        d_aluop = ALU_SLTU;
                    F_JR:          d_regdst = RD_RT;
                    default:       d_legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin d_aluop = ALU_ADD;  d_alusrc = AS_IMM; d_extsel = EXT_SIGN; end
            OP_SLTI:  begin d_aluop = ALU_SLT;  d_alusrc = AS_IMM; d_extsel = EXT_SIGN; end
            OP_SLTIU: begin d_aluop = ALU_SLTU; d_alusrc = AS_IMM; d_extsel = EXT_SIGN; end
            OP_ANDI:  begin d_aluop = ALU_AND;  d_alusrc = AS_IMM; end
            OP_ORI:   begin d_aluop = ALU_OR;   d_alusrc = AS_IMM; end
            OP_XORI:  begin d_aluop = ALU_XOR;  d_alusrc = AS_IMM; end
            OP_LUI:   begin d_aluop = ALU_ADD;  d_alusrc = AS_IMM; d_regsrc = RS_LUI; end
            OP_LW: begin
                d_aluop = ALU_ADD; d_alusrc = AS_IMM; d_extsel = EXT_SIGN; d_regsrc = RS_MEM;
            end
            OP_SW:         begin d_aluop = ALU_ADD; d_alusrc = AS_IMM; d_extsel = EXT_SIGN; end
            OP_BEQ, OP_BNE: begin d_aluop = ALU_SUB; d_extsel = EXT_SIGN; end
            OP_JAL:        begin d_regsrc = RS_PC; d_regdst = RD_R31; end
            OP_J, OP_HALT: ;
            default:       d_legal = 1'b0;
        endcase
    end

    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_bne    = (opcode == OP_BNE);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jmp    = (opcode == OP_J) || is_jal || (opcode == OP_RTYPE && funct == F_JR);
    assign exec_last = (ecnt == 4'(EXEC_CYCLES - 1));
    assign taken     = is_jmp || (is_beq && zero) || (is_bne && !zero);
    assign wait_hit  = (state == FETCH) ? ihit : dhit;
    // A hit in the limit cycle takes priority over the timeout.
    assign timeout   = (MEM_TIMEOUT != 0) && (state == FETCH || state == MEM) &&
                       !wait_hit && (wcnt == TLAST);

    always_comb begin
        nstate = state;
        case (state)
            FETCH:  if (ihit) nstate = DECODE; else if (timeout) nstate = HALT;
            DECODE: nstate = (opcode == OP_HALT || !d_legal) ? HALT : EXEC;
            EXEC: begin
                if (exec_last) begin
                    if (is_lw || is_sw)               nstate = MEM;
                    else if (is_jmp || is_beq || is_bne) nstate = FETCH;
                    else                              nstate = WB;
                end
            end
            MEM:     if (dhit) nstate = is_sw ? FETCH : WB; else if (timeout) nstate = HALT;
            WB:      nstate = FETCH;
            HALT:    nstate = HALT;
            default: nstate = FETCH;
        endcase
    end

    assign retire = (state == EXEC || state == MEM || state == WB) && (nstate == FETCH);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= FETCH;
            wcnt    <= '0;
            ecnt    <= '0;
            fault   <= 1'b0;
            instret <= '0;
        end else begin
            state <= nstate;
            wcnt  <= (nstate != state) ? '0 : wcnt + TW'(1);
            ecnt  <= (state == EXEC && nstate == EXEC) ? ecnt + 4'd1 : '0;
            if (nstate == HALT && state != HALT)
                fault <= !(state == DECODE && opcode == OP_HALT);
            if (retire && instret != '1)
                instret <= instret + CNT_W'(1);
        end
    end

    // FETCH is the reset state, so fetch strobes are masked while RST is held.
    always_comb begin
        active = (state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB);
        iREN   = (state == FETCH) && !RST;
        irWEN  = (state == FETCH) && !RST && ihit;
        pcWEN  = ((state == FETCH) && !RST && ihit) || ((state == EXEC) && exec_last && taken);
        dREN   = (state == MEM) && is_lw;
        dWEN   = (state == MEM) && is_sw;
        regWEN = (state == WB) || ((state == EXEC) && exec_last && is_jal);
        halt   = (state == HALT);
        regsrc = active ? d_regsrc : '0;
        regdst = active ? d_regdst : '0;
        extsel = active ? d_extsel : 1'b0;
        alusrc = active ? d_alusrc : '0;
        aluop  = active ? d_aluop  : '0;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (fast EXEC with fetch/mem timeout,
// slow EXEC with narrow saturating counter) driven by per-instruction expected traces.
module tb_multicycle_control_unit;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_HALT = 8, K_ILL = 9;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [10:0] fx;
        int          kind;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [1:0]       ihit = '0, dhit = '0, zero = '0;
    logic [1:0][5:0]  opc = '0, fnc = '0;
    logic [1:0]       iren, irwen, pcwen, dren, dwen, regwen, halt, fault, extsel;
    logic [1:0][1:0]  regsrc, regdst, alusrc;
    logic [1:0][3:0]  aluop;
    logic [31:0]      ret0;
    logic [2:0]       ret1;

    int          ncmp = 0, nerr = 0;
    logic        mh [2];
    logic        mf [2];
    logic [31:0] mret [2];
    ins_t        tbl [$];

    multicycle_control_unit #(.EXEC_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_a (
        .CLK(clk), .RST(rst), .ihit(ihit[0]), .dhit(dhit[0]), .opcode(opc[0]), .funct(fnc[0]),
        .zero(zero[0]), .iREN(iren[0]), .irWEN(irwen[0]), .pcWEN(pcwen[0]), .dREN(dren[0]),
        .dWEN(dwen[0]), .regWEN(regwen[0]), .regsrc(regsrc[0]), .regdst(regdst[0]),
        .extsel(extsel[0]), .alusrc(alusrc[0]), .aluop(aluop[0]), .halt(halt[0]),
        .fault(fault[0]), .instret(ret0)
    );

    multicycle_control_unit #(.EXEC_CYCLES(3), .MEM_TIMEOUT(0), .CNT_W(3)) dut_b (
        .CLK(clk), .RST(rst), .ihit(ihit[1]), .dhit(dhit[1]), .opcode(opc[1]), .funct(fnc[1]),
        .zero(zero[1]), .iREN(iren[1]), .irWEN(irwen[1]), .pcWEN(pcwen[1]), .dREN(dren[1]),
        .dWEN(dwen[1]), .regWEN(regwen[1]), .regsrc(regsrc[1]), .regdst(regdst[1]),
        .extsel(extsel[1]), .alusrc(alusrc[1]), .aluop(aluop[1]), .halt(halt[1]),
        .fault(fault[1]), .instret(ret1)
    );

    function automatic int ecyc(input int d); return (d != 0) ? 3 : 1; endfunction
    function automatic int tmo(input int d);  return (d != 0) ? 0 : 4; endfunction
    function automatic logic [31:0] rmax(input int d);
        return (d != 0) ? 32'd7 : 32'hFFFF_FFFF;
    endfunction
    function automatic logic rb(); return 1'($urandom_range(0, 1)); endfunction

    function automatic logic [7:0] ctrl(input int d);
        return {iren[d], irwen[d], pcwen[d], dren[d], dwen[d], regwen[d], halt[d], fault[d]};
    endfunction
    function automatic logic [10:0] fields(input int d);
        return {regsrc[d], regdst[d], extsel[d], alusrc[d], aluop[d]};
    endfunction
    function automatic logic [31:0] instret(input int d);
        return (d != 0) ? {29'd0, ret1} : ret0;
    endfunction

    function automatic logic [10:0] fxv(input int rs, input int rd, input int ext,
                                        input int as, input int op);
        return {2'(rs), 2'(rd), 1'(ext), 2'(as), 4'(op)};
    endfunction

    function automatic void add(input logic [5:0] op, input logic [5:0] fn,
                                input logic [10:0] fx, input int kind);
        ins_t e;
        e.op = op; e.fn = fn; e.fx = fx; e.kind = kind;
        tbl.push_back(e);
    endfunction

    function automatic int find(input logic [5:0] op, input logic [5:0] fn);
        foreach (tbl[i]) if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn)) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check just after.
    task automatic step(input int d, input logic [5:0] op, input logic [5:0] fn,
                        input logic ih, input logic dh, input logic z, input logic [5:0] c6,
                        input logic fe, input logic [10:0] fx, input string tag);
        @(negedge clk);
        ihit = '0;
        dhit = '0;
        ihit[d] = ih;
        dhit[d] = dh;
        zero[d] = z;
        opc[d]  = op;
        fnc[d]  = fn;
        #1;
        chk({tag, " ctrl"}, {24'd0, ctrl(d)}, {24'd0, c6, mh[d], mf[d]});
        if (fe) chk({tag, " fields"}, {21'd0, fields(d)}, {21'd0, fx});
        chk({tag, " instret"}, instret(d), mret[d]);
    endtask

    task automatic run_ins(input int d, input logic [5:0] op, input logic [5:0] fn,
                           input logic [10:0] fx, input int kind, input logic z,
                           input int wi, input int wd);
        int t, e;
        logic last, pc;
        t = tmo(d);
        e = ecyc(d);
        for (int k = 0; k <= wi; k++) begin
            if (t > 0 && k == t) begin mh[d] = 1'b1; mf[d] = 1'b1; return; end
            step(d, op, fn, k == wi, rb(), rb(), {1'b1, k == wi, k == wi, 3'b000}, 1'b0, '0, "fetch");
        end
        step(d, op, fn, rb(), rb(), rb(), 6'b0, kind != K_ILL, fx, "decode");
        if (kind == K_HALT) begin mh[d] = 1'b1; return; end
        if (kind == K_ILL)  begin mh[d] = 1'b1; mf[d] = 1'b1; return; end
        for (int c = 0; c < e; c++) begin
            last = (c == e - 1);
            pc = last && (kind == K_J || kind == K_JAL || kind == K_JR ||
                          (kind == K_BEQ && z) || (kind == K_BNE && !z));
            step(d, op, fn, rb(), rb(), last ? z : rb(),
                 {2'b00, pc, 2'b00, last && kind == K_JAL}, 1'b1, fx, "exec");
        end
        if (kind == K_LW || kind == K_SW) begin
            for (int m = 0; m <= wd; m++) begin
                if (t > 0 && m == t) begin mh[d] = 1'b1; mf[d] = 1'b1; return; end
                step(d, op, fn, rb(), m == wd, rb(),
                     {3'b000, kind == K_LW, kind == K_SW, 1'b0}, 1'b1, fx, "mem");
            end
        end
        if (kind == K_ALU || kind == K_LW)
            step(d, op, fn, rb(), rb(), rb(), 6'b000001, 1'b1, fx, "wb");
        if (mret[d] != rmax(d)) mret[d] = mret[d] + 32'd1;
    endtask

    task automatic run_tbl(input int d, input int idx, input logic z, input int wi, input int wd);
        ins_t e;
        e = tbl[idx];
        if (e.op != 6'h00) e.fn = 6'($urandom);
        run_ins(d, e.op, e.fn, e.fx, e.kind, z, wi, wd);
    endtask

    task automatic halt_steps(input int d, input int n);
        for (int i = 0; i < n; i++)
            step(d, opc[d], fnc[d], rb(), rb(), rb(), 6'b0, 1'b0, '0, "halted");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        ihit = '0;
        dhit = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset ctrl", {24'd0, ctrl(d)}, 32'd0);
            chk("reset fields", {21'd0, fields(d)}, 32'd0);
            chk("reset instret", instret(d), 32'd0);
            mh[d] = 1'b0; mf[d] = 1'b0; mret[d] = '0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int i_addu, i_lw, i_sw, i_beq, i_ori;
        ins_t e;
        for (int d = 0; d < 2; d++) begin mh[d] = 1'b0; mf[d] = 1'b0; mret[d] = '0; end
        add(6'h00, 6'h00, fxv(0, 1, 0, 2, 0), K_ALU);
        add(6'h00, 6'h02, fxv(0, 1, 0, 2, 1), K_ALU);
        add(6'h00, 6'h20, fxv(0, 1, 0, 0, 2), K_ALU);
        add(6'h00, 6'h21, fxv(0, 1, 0, 0, 2), K_ALU);
        add(6'h00, 6'h22, fxv(0, 1, 0, 0, 3), K_ALU);
        add(6'h00, 6'h23, fxv(0, 1, 0, 0, 3), K_ALU);
        add(6'h00, 6'h24, fxv(0, 1, 0, 0, 4), K_ALU);
        add(6'h00, 6'h25, fxv(0, 1, 0, 0, 5), K_ALU);
        add(6'h00, 6'h26, fxv(0, 1, 0, 0, 6), K_ALU);
        add(6'h00, 6'h27, fxv(0, 1, 0, 0, 7), K_ALU);
        add(6'h00, 6'h2A, fxv(0, 1, 0, 0, 8), K_ALU);
        add(6'h00, 6'h2B, fxv(0, 1, 0, 0, 9), K_ALU);
        add(6'h00, 6'h08, fxv(0, 0, 0, 0, 0), K_JR);
        add(6'h09, 6'h00, fxv(0, 0, 1, 1, 2), K_ALU);
        add(6'h0A, 6'h00, fxv(0, 0, 1, 1, 8), K_ALU);
        add(6'h0B, 6'h00, fxv(0, 0, 1, 1, 9), K_ALU);
        add(6'h0C, 6'h00, fxv(0, 0, 0, 1, 4), K_ALU);
        add(6'h0D, 6'h00, fxv(0, 0, 0, 1, 5), K_ALU);
        add(6'h0E, 6'h00, fxv(0, 0, 0, 1, 6), K_ALU);
        add(6'h0F, 6'h00, fxv(3, 0, 0, 1, 2), K_ALU);
        add(6'h23, 6'h00, fxv(1, 0, 1, 1, 2), K_LW);
        add(6'h2B, 6'h00, fxv(0, 0, 1, 1, 2), K_SW);
        add(6'h04, 6'h00, fxv(0, 0, 1, 0, 3), K_BEQ);
        add(6'h05, 6'h00, fxv(0, 0, 1, 0, 3), K_BNE);
        add(6'h02, 6'h00, fxv(0, 0, 0, 0, 0), K_J);
        add(6'h03, 6'h00, fxv(2, 2, 0, 0, 0), K_JAL);
        i_addu = find(6'h00, 6'h21);
        i_lw   = find(6'h23, 6'h00);
        i_sw   = find(6'h2B, 6'h00);
        i_beq  = find(6'h04, 6'h00);
        i_ori  = find(6'h0D, 6'h00);

        do_reset();
        run_tbl(0, i_addu, 1'b0, 0, 0);
        run_tbl(0, i_lw, 1'b0, 0, 3);
        run_tbl(0, i_beq, 1'b0, 0, 0);
        run_tbl(0, i_beq, 1'b1, 0, 0);
        repeat (30) run_tbl(0, $urandom_range(0, tbl.size() - 1), rb(),
                            $urandom_range(0, 3), $urandom_range(0, 3));
        run_tbl(0, i_addu, 1'b0, 3, 0);
        run_tbl(0, i_addu, 1'b0, 20, 0);
        halt_steps(0, 3);

        do_reset();
        run_tbl(0, i_sw, 1'b0, 0, 20);
        halt_steps(0, 3);

        do_reset();
        run_ins(0, 6'h00, 6'h01, '0, K_ILL, 1'b0, 0, 0);
        halt_steps(0, 2);
        do_reset();
        run_ins(0, 6'h3E, 6'h00, '0, K_ILL, 1'b0, 1, 0);
        halt_steps(0, 2);

        do_reset();
        run_tbl(0, i_addu, 1'b0, 0, 0);
        run_ins(0, 6'h3F, 6'($urandom), '0, K_HALT, 1'b0, 1, 0);
        halt_steps(0, 5);

        do_reset();
        e = tbl[i_lw];
        step(0, e.op, 6'h00, 1'b1, 1'b0, 1'b0, 6'b111000, 1'b0, '0, "abort fetch");
        step(0, e.op, 6'h00, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, e.fx, "abort decode");
        step(0, e.op, 6'h00, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, e.fx, "abort exec");
        step(0, e.op, 6'h00, 1'b0, 1'b0, 1'b0, 6'b000100, 1'b1, e.fx, "abort mem");
        do_reset();
        run_tbl(0, i_addu, 1'b0, 0, 0);

        do_reset();
        run_tbl(1, i_ori, 1'b0, 0, 0);
        run_tbl(1, i_addu, 1'b0, 6, 0);
        repeat (14) run_tbl(1, $urandom_range(0, tbl.size() - 1), rb(),
                            $urandom_range(0, 3), $urandom_range(0, 3));
        run_tbl(1, i_lw, 1'b0, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
